// File: rtl/hc595_pkg.sv
// Shared widths, FSM state type and storage-register unpacking for the 74HC595 receive model.
package hc595_pkg;

    localparam int SEL_WIDTH  = 6;
    localparam int SEG_WIDTH  = 8;
    localparam int FRAME_BITS = SEL_WIDTH + SEG_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    typedef struct packed {
        logic [SEL_WIDTH-1:0] selection;
        logic [SEG_WIDTH-1:0] seg;
    } frame_t;

    // Selection bits were shifted first (lowest register bits); segments follow MSB-first.
    function automatic frame_t unpack_frame(input logic [FRAME_BITS-1:0] sr);
        frame_t f;
        f.selection = sr[SEL_WIDTH-1:0];
        for (int k = 0; k < SEG_WIDTH; k++) begin
            f.seg[k] = sr[FRAME_BITS-1-k];
        end
        return f;
    endfunction

endpackage

// File: rtl/hc595_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with a rising-edge pulse on the synced copy.
module hc595_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign level = sync_reg[SYNC_STAGES-1];
    assign rise  = sync_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/hc595_receiver.sv
// Receive-side 74HC595 model: rebuilds digit selection and segment word from ds/shcp/stcp/oe.
// Optional bit-count checking of each frame is enabled with `define HC595_FRAME_CHECK_EN.
module hc595_receiver
    import hc595_pkg::*;
#(
    parameter int SEL_WIDTH   = hc595_pkg::SEL_WIDTH,
    parameter int SEG_WIDTH   = hc595_pkg::SEG_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 system_clock,
    input  logic                 system_reset_n,
    input  logic                 ds,
    input  logic                 shcp,
    input  logic                 stcp,
    input  logic                 oe,
    output logic [SEL_WIDTH-1:0] selection_out,
    output logic [SEG_WIDTH-1:0] seg_out,
    output logic                 frame_valid,
    output logic                 frame_err
);

    localparam int N       = SEL_WIDTH + SEG_WIDTH;
    localparam int IN_DS   = 0;
    localparam int IN_SHCP = 1;
    localparam int IN_STCP = 2;
    localparam int IN_OE   = 3;

    logic [3:0] raw;
    logic [3:0] level;
    logic [3:0] rise;

    assign raw = {oe, stcp, shcp, ds};

    // Identical synchronizers keep ds aligned with the shcp edge it is sampled on.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sync
            hc595_sync_edge #(
                .SYNC_STAGES(SYNC_STAGES)
            ) u_sync (
                .clk  (system_clock),
                .rst_n(system_reset_n),
                .din  (raw[gi]),
                .level(level[gi]),
                .rise (rise[gi])
            );
        end
    endgenerate

    logic unused_rise;
    assign unused_rise = rise[IN_DS] | rise[IN_OE];

    logic ds_s;
    logic oe_s;
    logic shcp_rise;
    logic stcp_rise;

    assign ds_s      = level[IN_DS];
    assign oe_s      = level[IN_OE];
    assign shcp_rise = rise[IN_SHCP];
    assign stcp_rise = rise[IN_STCP];

    state_t         state_reg, state_next;
    logic [N-1:0]   sr_reg;
    logic [N-1:0]   snap_reg;
    logic [N-1:0]   storage_reg;
    logic [4:0]     bit_cnt_reg;
    logic           ok_reg;
    logic           valid_reg;
    logic           frame_ok;

`ifdef HC595_FRAME_CHECK_EN
    assign frame_ok = (bit_cnt_reg == 5'(N));
`else
    assign frame_ok = 1'b1;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (stcp_rise) begin
                    state_next = LATCH;
                end else if (shcp_rise) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (stcp_rise) begin
                    state_next = LATCH;
                end
            end
            LATCH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // snap_reg holds the pre-shift register so a coincident shcp edge cannot leak into the frame.
    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state_reg   <= IDLE;
            sr_reg      <= '0;
            snap_reg    <= '0;
            storage_reg <= '0;
            bit_cnt_reg <= '0;
            ok_reg      <= 1'b0;
            valid_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (shcp_rise) begin
                sr_reg <= {ds_s, sr_reg[N-1:1]};
            end
            if (stcp_rise) begin
                bit_cnt_reg <= shcp_rise ? 5'd1 : 5'd0;
                snap_reg    <= sr_reg;
                ok_reg      <= frame_ok;
            end else if (shcp_rise && bit_cnt_reg != 5'd31) begin
                bit_cnt_reg <= bit_cnt_reg + 5'd1;
            end
            valid_reg <= (state_reg == LATCH) && ok_reg;
            if (state_reg == LATCH && ok_reg) begin
                storage_reg <= snap_reg;
            end
        end
    end

`ifdef HC595_FRAME_CHECK_EN
    logic err_reg;

    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= (state_reg == LATCH) && !ok_reg;
        end
    end

    assign frame_err = err_reg;
`else
    assign frame_err = 1'b0;
`endif

    frame_t fields;
    assign fields = unpack_frame(storage_reg);

    assign selection_out = oe_s ? '0 : fields.selection;
    assign seg_out       = oe_s ? '0 : fields.seg;
    assign frame_valid   = valid_reg;

endmodule
